debug_fifo: RTL and testbench
=============================

Name: debug_fifo

Overview:
Wishbone-readable capture FIFO that consumes the debug word stream (fifo_wr_in / fifo_wr_en) produced alongside the system register block. Fabric logic pushes 32-bit words one per cycle. Software drains them through a wishbone slave window and reads status and overflow flags from the same window. Single clock domain: the writer must be synchronous to wb_clk_i.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth in entries (depth = 16 by default; legal range 2..10)

Ports:
wb_clk_i  input  1  clock for all logic, including the push side
wb_rst_i  input  1  synchronous, active-high reset
wb_cyc_i  input  1  wishbone cycle
wb_stb_i  input  1  wishbone strobe
wb_we_i  input  1  wishbone write enable
wb_sel_i  input  4  byte selects; ignored, all accesses are full-word
wb_adr_i  input  32  byte address; only bits [3:2] are decoded
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data, registered
wb_ack_o  output  1  acknowledge, registered
wb_err_o  output  1  tied 0
fifo_wr_in  input  32  data to push
fifo_wr_en  input  1  push strobe, one word per cycle high

Behaviour:
- Reset (synchronous, active-high): clears wr_ptr, rd_ptr, count, the overflow and underflow stickies, drop_cnt, wb_ack_o and wb_dat_o to 0. RAM contents are don't-care. A push or access in the reset cycle has no effect.
- Storage: 2^DEPTH_LOG2 x 32 RAM. Pointers are DEPTH_LOG2 bits wide and wrap naturally. count is DEPTH_LOG2+1 bits, range 0..depth.
- Flags: empty = (count==0), full = (count==depth).
- Wishbone access: accepted on a cycle where stb & cyc & !wb_ack_o.
  - On the next cycle wb_ack_o=1 for exactly one cycle, with wb_dat_o valid.
  - Single-cycle latency; at most one access every 2 cycles.
  - Side effects (pop, control) occur once, in the accept cycle.
- Address map, wb_adr_i[3:2]:
  - 0 DATA (RO): returns the head word and pops it. If empty: returns 32'h0, no pop, sets underflow sticky.
  - 1 STATUS (RO): [15:0] count (zero-extended), [16] empty, [17] full, [18] overflow, [19] underflow, [23:20] 0, [31:24] drop_cnt.
  - 2 CTRL (WO, reads 0): bit0=1 flushes (ptrs and count to 0); bit1=1 clears overflow, underflow and drop_cnt. Both bits may be set in one write.
  - 3 PEEK: see Optional Feature.
  - Writes to addresses 0, 1 and 3 are acked and otherwise ignored.
- Push: fifo_wr_en & !full writes fifo_wr_in at wr_ptr, then wr_ptr+1 and count+1.
- Push while full: word dropped, overflow sticky set, drop_cnt+1 saturating at 255.
- Simultaneous push and pop:
  - Not empty: both occur, count unchanged.
  - Full: both occur (the pop frees the slot), no overflow.
  - Empty: the push occurs; the pop reads 0 and flags underflow. The pushed word is not bypassed.
- Flush in the same cycle as a push: flush wins and the push is discarded without flagging overflow.
- Flush and sticky clear both act in the accept cycle. The STATUS ack that follows reflects the post-action state only if the read is accepted on a later cycle.
- Read data is captured from the RAM/register state before that cycle's updates.

Optional Feature:
Macro: DEBUG_FIFO_TIMESTAMP_EN
- Defined:
  - A 32-bit free-running cycle counter (reset to 0, wraps) is stored alongside each pushed word.
  - PEEK (addr 3) returns the head entry's timestamp without popping, or 0 if empty.
  - A DATA pop advances both data and timestamp.
  - STATUS[20] reads 1.
- Undefined:
  - No counter or timestamp RAM is built.
  - PEEK reads 32'h0.
  - STATUS[20] reads 0.

Test Plan:
- Reset, then read STATUS -> 32'h0001_0000 (empty=1, count=0). Read DATA -> 0, and a later STATUS read shows underflow=1 (32'h0009_0000).
- Push 0xA0..0xA2 on consecutive cycles, then 3 DATA reads -> 0xA0, 0xA1, 0xA2 in order. Following STATUS: count=0, empty=1.
- With DEPTH_LOG2=4, push 20 words 0..19 -> STATUS count=16, full=1, overflow=1, drop_cnt=4. DATA reads return 0..15. Write CTRL=2 -> STATUS 32'h0001_0000.
- Fill to 16, then hold fifo_wr_en=1 with data 0x55 in the DATA accept cycle -> returns word 0, count stays 16, overflow stays 0, and 0x55 is the last word drained.
- Push 5 words, then write CTRL=1 while fifo_wr_en=1 in the same cycle -> count=0, overflow=0, next DATA read returns 0 with underflow set.
- DEBUG_FIFO_TIMESTAMP_EN: push at counter values 100 and 107 -> PEEK returns 100 twice; DATA pop; PEEK returns 107. Undefined build: PEEK returns 0.

Source files
------------

// File: rtl/debug_fifo_if.sv
// Wishbone slave window of the debug capture FIFO.
interface debug_fifo_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/debug_fifo.sv
// Wishbone-readable debug capture FIFO with status/overflow flags.
// Optional per-entry timestamps: define DEBUG_FIFO_TIMESTAMP_EN.
module debug_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  debug_fifo_if.slave wb,
  input  logic [31:0] fifo_wr_in,
  input  logic        fifo_wr_en
);
  localparam int Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [7:0]  drop_q, drop_d;
  logic        ack_q;
  logic [31:0] dat_q, dat_d;
  logic [31:0] mem_q [Depth];

  logic        empty;
  logic        full;
  logic        accept;
  logic        rd_acc;
  logic        wr_acc;
  logic        data_rd;
  logic        pop;
  logic        push;
  logic        flush;
  logic        clr;
  logic        ovf_ev;
  logic [1:0]  addr;
  logic [31:0] status;
  logic [31:0] peek;
  logic [31:0] rdata;
  logic        unused_w;

  assign empty   = (count_q == '0);
  assign full    = (count_q == cnt_t'(Depth));
  assign accept  = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign addr    = wb.wb_adr_i[3:2];
  assign rd_acc  = accept & ~wb.wb_we_i;
  assign wr_acc  = accept & wb.wb_we_i;
  assign data_rd = rd_acc & (addr == 2'd0);
  assign pop     = data_rd & ~empty;
  assign flush   = wr_acc & (addr == 2'd2)
                 & wb.wb_dat_i[0];
  assign clr     = wr_acc & (addr == 2'd2)
                 & wb.wb_dat_i[1];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = fifo_wr_en & ~flush
                 & (~full | pop);
  assign ovf_ev  = fifo_wr_en & ~flush
                 & full & ~pop;

`ifdef DEBUG_FIFO_TIMESTAMP_EN
  localparam logic TsEn = 1'b1;

  logic [31:0] ts_q;
  logic [31:0] ts_mem_q [Depth];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      ts_mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign peek = empty ? '0 : ts_mem_q[rd_ptr_q];
`else
  localparam logic TsEn = 1'b0;

  assign peek = '0;
`endif

  assign status = {
    drop_q,
    3'b000,
    TsEn,
    unf_q,
    ovf_q,
    full,
    empty,
    16'(count_q)
  };

  always_comb begin
    rdata = '0;
    unique case (addr)
      2'd0:    rdata = empty ? '0 : mem_q[rd_ptr_q];
      2'd1:    rdata = status;
      2'd3:    rdata = peek;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    drop_d   = drop_q;
    dat_d    = dat_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    count_d = count_q + cnt_t'(push)
            - cnt_t'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    if (clr) begin
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      drop_d = '0;
    end
    if (data_rd & empty) begin
      unf_d = 1'b1;
    end
    // A drop in the clearing cycle still counts: set beats clear.
    if (ovf_ev) begin
      ovf_d = 1'b1;
      if (drop_d != 8'hff) begin
        drop_d = drop_d + 8'd1;
      end
    end
    if (accept) begin
      dat_d = wb.wb_we_i ? '0 : rdata;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      drop_q   <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      drop_q   <= drop_d;
      ack_q    <= accept;
      dat_q    <= dat_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fifo_wr_in;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_err_o = 1'b0;

  assign unused_w = ^{
    wb.wb_sel_i,
    wb.wb_dat_i[31:2],
    wb.wb_adr_i[31:4],
    wb.wb_adr_i[1:0]
  };
endmodule

// File: tb/tb_debug_fifo.sv
// Self-checking bench for debug_fifo: queue-based reference model,
// per-cycle output compare, directed literal checks and random traffic.
module tb_debug_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef DEBUG_FIFO_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif
  localparam logic [31:0] TSB = TS ? 32'h0010_0000 : 32'h0;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [31:0] wr_in = '0;
  logic        wr_en = 1'b0;

  debug_fifo_if bus ();

  debug_fifo #(
    .DEPTH_LOG2(DL)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (bus),
    .fifo_wr_in(wr_in),
    .fifo_wr_en(wr_en)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  // Reference model
  int unsigned mq[$];
  int unsigned tq[$];
  logic        m_ovf   = 1'b0;
  logic        m_unf   = 1'b0;
  int          m_drop  = 0;
  int unsigned m_ts    = 0;
  logic        exp_ack = 1'b0;
  logic [31:0] exp_dat = '0;
  bit          checking = 1'b0;

  always @(posedge clk) begin : model
    logic        acc;
    logic        fl;
    logic [1:0]  a;
    logic [31:0] rd;
    logic [7:0]  dr;
    if (rst) begin
      mq.delete();
      tq.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_drop  = 0;
      m_ts    = 0;
      exp_ack = 1'b0;
      exp_dat = '0;
    end else begin
      acc = bus.wb_cyc_i && bus.wb_stb_i
            && !exp_ack;
      a   = bus.wb_adr_i[3:2];
      rd  = '0;
      fl  = 1'b0;
      dr  = 8'(m_drop);
      if (acc && !bus.wb_we_i) begin
        case (a)
          2'd0: begin
            if (mq.size() > 0) begin
              rd = mq.pop_front();
              void'(tq.pop_front());
            end else begin
              m_unf = 1'b1;
            end
          end
          2'd1: rd = {dr, 3'b000, TS,
                      m_unf, m_ovf,
                      mq.size() == DEPTH,
                      mq.size() == 0,
                      16'(mq.size())};
          2'd3: if (TS && mq.size() > 0)
                  rd = tq[0];
          default: rd = '0;
        endcase
      end
      if (acc && bus.wb_we_i && a == 2'd2) begin
        fl = bus.wb_dat_i[0];
        if (fl) begin
          mq.delete();
          tq.delete();
        end
        if (bus.wb_dat_i[1]) begin
          m_ovf  = 1'b0;
          m_unf  = 1'b0;
          m_drop = 0;
        end
      end
      if (wr_en && !fl) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(wr_in);
          tq.push_back(m_ts);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (acc) exp_dat = bus.wb_we_i ? '0 : rd;
      exp_ack = acc;
      m_ts++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("ack", 32'(bus.wb_ack_o), 32'(exp_ack));
      chk("err", 32'(bus.wb_err_o), 32'h0);
      if (exp_ack)
        chk("dat", bus.wb_dat_o, exp_dat);
    end
  end

  // All tasks start and end on a negedge.
  task automatic access(input logic we,
                        input logic [1:0] a,
                        input logic [31:0] wd,
                        input logic pe,
                        input logic [31:0] pd,
                        output logic [31:0] rd);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = {28'h0, a, 2'b00};
    bus.wb_dat_i = wd;
    wr_en        = pe;
    wr_in        = pd;
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    wr_en        = 1'b0;
    chk("acc_ack", 32'(bus.wb_ack_o), 32'h1);
    rd = bus.wb_dat_o;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name,
                        input logic [1:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    access(1'b0, a, '0, 1'b0, '0, d);
    chk(name, d, exp);
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    logic [31:0] r;
    access(1'b1, a, d, 1'b0, '0, r);
  endtask

  task automatic push(input logic [31:0] w);
    wr_en = 1'b1;
    wr_in = w;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] p1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'hf;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    checking = 1'b1;

    rd_chk("rst_status", 2'd1, 32'h0001_0000 | TSB);
    rd_chk("empty_data", 2'd0, 32'h0);
    rd_chk("unf_status", 2'd1, 32'h0009_0000 | TSB);
    rd_chk("ctrl_reads0", 2'd2, 32'h0);
    wr(2'd2, 32'h3);

    push(32'hA0);
    push(32'hA1);
    push(32'hA2);
    rd_chk("ord0", 2'd0, 32'hA0);
    rd_chk("ord1", 2'd0, 32'hA1);
    rd_chk("ord2", 2'd0, 32'hA2);
    rd_chk("ord_status", 2'd1, 32'h0001_0000 | TSB);

    for (int i = 0; i < 20; i++) push(32'(i));
    rd_chk("ovf_status", 2'd1, 32'h0406_0010 | TSB);
    for (int i = 0; i < 16; i++)
      rd_chk("ovf_drain", 2'd0, 32'(i));
    wr(2'd2, 32'h2);
    rd_chk("clr_status", 2'd1, 32'h0001_0000 | TSB);

    for (int i = 0; i < 16; i++) push(32'(100 + i));
    access(1'b0, 2'd0, '0, 1'b1, 32'h55, d);
    chk("full_pp_data", d, 32'd100);
    rd_chk("full_pp_status", 2'd1, 32'h0002_0010 | TSB);
    for (int i = 0; i < 16; i++)
      access(1'b0, 2'd0, '0, 1'b0, '0, d);
    chk("full_pp_last", d, 32'h55);

    for (int i = 0; i < 5; i++) push(32'(200 + i));
    access(1'b1, 2'd2, 32'h1, 1'b1, 32'hEE, d);
    rd_chk("flush_status", 2'd1, 32'h0001_0000 | TSB);
    rd_chk("flush_data", 2'd0, 32'h0);
    rd_chk("flush_unf", 2'd1, 32'h0009_0000 | TSB);
    wr(2'd2, 32'h3);

`ifdef DEBUG_FIFO_TIMESTAMP_EN
    push(32'h11);
    repeat (6) @(negedge clk);
    push(32'h22);
    access(1'b0, 2'd3, '0, 1'b0, '0, p1);
    rd_chk("peek_again", 2'd3, p1);
    rd_chk("peek_pop", 2'd0, 32'h11);
    rd_chk("peek_next", 2'd3, p1 + 32'd7);
    rd_chk("peek_pop2", 2'd0, 32'h22);
`else
    push(32'h77);
    rd_chk("peek_off", 2'd3, 32'h0);
    rd_chk("peek_pop", 2'd0, 32'h77);
    p1 = '0;
`endif

    for (int i = 0; i < 3000; i++) begin
      wr_en        = ($urandom_range(0, 9) < 6);
      wr_in        = $urandom;
      bus.wb_stb_i = ($urandom_range(0, 2) == 0);
      bus.wb_cyc_i = bus.wb_stb_i
                     | ($urandom_range(0, 1) == 0);
      bus.wb_we_i  = ($urandom_range(0, 7) == 0);
      bus.wb_adr_i = $urandom;
      bus.wb_sel_i = 4'($urandom);
      bus.wb_dat_i = $urandom;
      if (i % 700 == 350) rst = 1'b1;
      else rst = 1'b0;
      @(negedge clk);
    end
    rst          = 1'b0;
    wr_en        = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
